// File: rtl/state_vec_decoder_if.sv
// Stream bundle for the state-vector decoder: one-hot vector in, decoded index out.
// Master drives vectors and consumes results; slave is the decoder.
interface state_vec_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       out_err;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_err
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_err
  );
endinterface

// File: rtl/state_vec_decoder.sv
// Decodes 2-qubit basis vectors to an index and histograms them over a counted run.
// Latency: 1 cycle from accept to out_valid through a single output register.
// Backpressure: in_ready = !out_valid || out_ready; run FSM never stalls the datapath.
module state_vec_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  state_vec_decoder_if.slave io,
  input  logic             start,
  input  logic [CNT_W-1:0] shot_count,
  output logic             busy,
  output logic             done,
  input  logic [1:0]       hist_sel,
  output logic [CNT_W-1:0] hist_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [1:0] idx;
    logic       err;
  } dec_t;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  dec_t   dec;
  dec_t   res_q, res_d;
  logic   out_valid_q, out_valid_d;
  cnt_t   shot_q, shot_d;
  cnt_t   target_q, target_d;
  cnt_t   err_q, err_d;
  cnt_t   bin_q [4];
  cnt_t   bin_d [4];
  logic   accept;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    dec = '{idx: 2'd0, err: 1'b1};
    case (io.in_vec)
      4'b1000: dec = '{idx: 2'd0, err: 1'b0};
      4'b0100: dec = '{idx: 2'd1, err: 1'b0};
      4'b0010: dec = '{idx: 2'd2, err: 1'b0};
      4'b0001: dec = '{idx: 2'd3, err: 1'b0};
      default: dec = '{idx: 2'd0, err: 1'b1};
    endcase
  end

  assign io.in_ready = !out_valid_q || io.out_ready;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d       = dec;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    shot_d   = shot_q;
    target_d = target_q;
    err_d    = err_q;
    bin_d    = bin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shot_d   = '0;
          err_d    = '0;
          bin_d    = '{default: '0};
          target_d = shot_count;
          state_d  = (shot_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Counting taps the same decode that loads the output register.
        if (accept) begin
          shot_d = shot_q + CNT_ONE;
          if (dec.err) err_d = sat_inc(err_q);
          else         bin_d[dec.idx] = sat_inc(bin_q[dec.idx]);
          if (shot_d == target_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      shot_q      <= '0;
      target_q    <= '0;
      err_q       <= '0;
      bin_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      shot_q      <= shot_d;
      target_q    <= target_d;
      err_q       <= err_d;
      bin_q       <= bin_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_idx   = res_q.idx;
  assign io.out_err   = res_q.err;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign hist_cnt     = bin_q[hist_sel];
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_state_vec_decoder.sv
// Scoreboard bench: driver pushes expected decodes and updates a run-level histogram model;
// a negedge monitor compares every DUT output against the model.
module tb_state_vec_decoder;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic [1:0] idx;
    logic       err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] shot_count = '0;
  logic             busy, done;
  logic [1:0]       hist_sel = 2'd0;
  logic [CNT_W-1:0] hist_cnt, err_cnt;

  state_vec_decoder_if io ();

  state_vec_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .start      (start),
    .shot_count (shot_count),
    .busy       (busy),
    .done       (done),
    .hist_sel   (hist_sel),
    .hist_cnt   (hist_cnt),
    .err_cnt    (err_cnt)
  );

  always #10 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  int   m_bins[4];
  int   m_err = 0;
  int   run_left = 0;
  bit   in_run = 1'b0;
  bit   done_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_decode(input logic [3:0] v);
    res_t r;
    r.idx = 2'd0;
    r.err = 1'b1;
    if ($countones(v) == 1) begin
      r.err = 1'b0;
      for (int i = 0; i < 4; i++)
        if (v[i]) r.idx = 2'(3 - i);
    end
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // Advance the reference by one rising edge, given what was presented before it.
  task automatic model_edge(input bit st, input bit acc, input logic [3:0] vec, input int shot);
    res_t r;
    bit   nd;
    r  = ref_decode(vec);
    nd = 1'b0;
    if (in_run) begin
      if (acc) begin
        if (r.err) m_err = sat(m_err);
        else       m_bins[r.idx] = sat(m_bins[r.idx]);
        run_left--;
        if (run_left == 0) begin
          in_run = 1'b0;
          nd     = 1'b1;
        end
      end
    end else if (!done_exp && st) begin
      m_bins = '{0, 0, 0, 0};
      m_err  = 0;
      if (shot == 0) nd = 1'b1;
      else begin
        in_run   = 1'b1;
        run_left = shot;
      end
    end
    done_exp = nd;
    if (acc) exp_q.push_back(r);
  endtask

  // Entered and left just after a rising edge.
  task automatic cycle(input bit st, input bit iv, input logic [3:0] vec, input bit ordy,
                       input logic [CNT_W-1:0] shot);
    bit acc;
    start        = st;
    io.in_valid  = iv;
    io.in_vec    = vec;
    io.out_ready = ordy;
    shot_count   = shot;
    hist_sel     = 2'($urandom_range(0, 3));
    @(negedge clk);
    acc = iv && (io.in_ready === 1'b1);
    @(posedge clk);
    #1;
    model_edge(st, acc, vec, int'(shot));
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    io.in_valid = 1'b0;
    exp_q.delete();
    m_bins   = '{0, 0, 0, 0};
    m_err    = 0;
    in_run   = 1'b0;
    done_exp = 1'b0;
    run_left = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input int b0, input int b1, input int b2, input int b3, input int e);
    int exp_b[4];
    exp_b = '{b0, b1, b2, b3};
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      chk($sformatf("bin%0d", s), 32'(hist_cnt), exp_b[s]);
    end
    chk("err_cnt", 32'(err_cnt), e);
  endtask

  always @(negedge clk) begin
    bit exp_v;
    exp_v = (exp_q.size() != 0);
    chk("out_valid", 32'(io.out_valid), 32'(exp_v));
    chk("in_ready", 32'(io.in_ready), 32'(!exp_v || io.out_ready));
    if (exp_v) begin
      chk("out_idx", 32'(io.out_idx), 32'(exp_q[0].idx));
      chk("out_err", 32'(io.out_err), 32'(exp_q[0].err));
      if (io.out_ready) void'(exp_q.pop_front());
    end
    chk("busy", 32'(busy), 32'(in_run));
    chk("done", 32'(done), 32'(done_exp));
    chk("hist_cnt", 32'(hist_cnt), m_bins[hist_sel]);
    chk("err_cnt_mon", 32'(err_cnt), m_err);
  end

  initial begin
    io.in_valid  = 1'b0;
    io.in_vec    = 4'b0000;
    io.out_ready = 1'b0;
    m_bins       = '{0, 0, 0, 0};
    do_reset();
    chk("rst_out_valid", 32'(io.out_valid), 0);
    chk("rst_in_ready", 32'(io.in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    check_counts(0, 0, 0, 0, 0);

    // Back-to-back one-hot decode
    cycle(0, 1, 4'b1000, 1, 0);
    cycle(0, 1, 4'b0100, 1, 0);
    cycle(0, 1, 4'b0010, 1, 0);
    cycle(0, 1, 4'b0001, 1, 0);
    cycle(0, 0, 4'b0000, 1, 0);

    // Error vectors while idle leave err_cnt untouched
    cycle(0, 1, 4'b0000, 1, 0);
    cycle(0, 1, 4'b0110, 1, 0);
    cycle(0, 0, 4'b0000, 1, 0);
    chk("idle_err_cnt", 32'(err_cnt), 0);

    // Backpressure: first result held, second waits for out_ready
    cycle(0, 1, 4'b0100, 0, 0);
    cycle(0, 1, 4'b0001, 0, 0);
    cycle(0, 1, 4'b0001, 0, 0);
    cycle(0, 1, 4'b0001, 1, 0);
    cycle(0, 0, 4'b0000, 1, 0);
    cycle(0, 0, 4'b0000, 1, 0);

    // Five-shot run
    cycle(1, 0, 4'b0000, 1, 5);
    chk("run5_busy", 32'(busy), 1);
    cycle(0, 1, 4'b0001, 1, 0);
    cycle(0, 1, 4'b0001, 1, 0);
    cycle(0, 1, 4'b1000, 1, 0);
    cycle(0, 1, 4'b0011, 1, 0);
    cycle(0, 1, 4'b0100, 1, 0);
    chk("run5_done", 32'(done), 1);
    chk("run5_busy_end", 32'(busy), 0);
    cycle(0, 0, 4'b0000, 1, 0);
    chk("run5_done_clear", 32'(done), 0);
    check_counts(1, 1, 0, 2, 1);

    // Zero-shot run
    cycle(1, 0, 4'b0000, 1, 0);
    chk("zero_done", 32'(done), 1);
    cycle(0, 0, 4'b0000, 1, 0);
    check_counts(0, 0, 0, 0, 0);

    // Start during RUN ignored, target stays 4
    cycle(1, 0, 4'b0000, 1, 4);
    cycle(0, 1, 4'b1000, 1, 0);
    cycle(1, 1, 4'b0100, 1, 9);
    cycle(0, 1, 4'b0010, 1, 0);
    cycle(0, 1, 4'b0001, 1, 0);
    chk("restart_done", 32'(done), 1);
    cycle(0, 0, 4'b0000, 1, 0);
    check_counts(1, 1, 1, 1, 0);

    // Reset after 3 of 8 shots, then a clean run
    cycle(1, 0, 4'b0000, 1, 8);
    cycle(0, 1, 4'b1000, 1, 0);
    cycle(0, 1, 4'b0010, 1, 0);
    cycle(0, 1, 4'b0110, 0, 0);
    do_reset();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_out_valid", 32'(io.out_valid), 0);
    check_counts(0, 0, 0, 0, 0);
    cycle(1, 0, 4'b0000, 1, 2);
    cycle(0, 1, 4'b0100, 1, 0);
    cycle(0, 1, 4'b1111, 1, 0);
    cycle(0, 0, 4'b0000, 1, 0);
    check_counts(0, 1, 0, 0, 1);

    // Full-scale run of identical vectors; extras land after DONE and are not counted
    cycle(1, 0, 4'b0000, 1, 4'(MAXC));
    for (int k = 0; k < 20; k++) cycle(0, 1, 4'b0010, 1, 0);
    cycle(0, 0, 4'b0000, 1, 0);
    check_counts(0, 0, MAXC, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      logic [3:0] v;
      if ($urandom_range(0, 3) != 0) v = 4'(1 << $urandom_range(0, 3));
      else                           v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, v,
                 $urandom_range(0, 3) != 0, CNT_W'($urandom_range(0, MAXC)));
    end
    repeat (3) cycle(0, 0, 4'b0000, 1, 0);
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
